trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Parametrised, multi-cycle machine-mode trap sequencer for the RV32I core; successor to the single-cycle trap controller. It sits between the decode/execute trap detection logic, the CSR file and the PC controller. It serialises mepc/mcause/mstatus/mtvec accesses through one CSR port and adds prioritised interrupt channels, vectored mtvec mode, MRET return and an optional debug halt. It stalls the pipeline while a sequence runs and redirects the PC when the sequence finishes.

## Interface
- XLEN, 32, datapath width of PC and CSR data.
- NIRQ, 4, number of interrupt request lines (1..16).
- IRQ_BASE, 16, mcause code of irq[0]; irq[i] uses IRQ_BASE+i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  XLEN  PC of the trapping or returning instruction.
- trap_status  in  3  000 none, 001 EBREAK, 010 ECALL, 011 misaligned fetch, 100 illegal, 101 misaligned load/store, 110 MRET, 111 reserved.
- irq  in  NIRQ  level interrupt requests.
- mstatus_mie  in  1  direct tap of mstatus.MIE.
- debug_resume  in  1  single-cycle resume request from the debug module.
- csr_rd  in  XLEN  combinational read data for csr_trap_address.
- t_target  out  XLEN  redirect target; valid when trap_done is high, held afterwards.
- trap_done  out  1  one-cycle redirect strobe to the PC controller.
- trap_busy  out  1  pipeline stall.
- ic_clean  out  1  instruction-cache/fetch flush pulse.
- debug_mode  out  1  core halted in debug.
- csr_trap_address  out  12  CSR address driven by the sequencer.
- csr_trap_write_data  out  XLEN  CSR write data.
- csr_trap_we  out  1  CSR write enable; the write commits on the rising edge.

## Operation
- Cause mapping:
  - ECALL: 11.
  - Misaligned fetch: 0.
  - Illegal: 2.
  - Misaligned load/store: 4.
  - Reserved: 2.
  - EBREAK: 3 (see Configuration).
  - Interrupt: bit XLEN-1 set, code IRQ_BASE+i.
- Arbitration in IDLE:
  - A nonzero trap_status always wins over irq.
  - An interrupt is taken only when trap_status==000 and mstatus_mie==1.
  - The lowest set irq index wins.
- States: IDLE, MEPC, MCAUSE, MSTATUS, MTVEC, REDIRECT, DEBUG.
- Entry: on acceptance in IDLE, latch pc, the cause and the kind (exception, interrupt or MRET).
- Exception or interrupt path: IDLE→MEPC→MCAUSE→MSTATUS→MTVEC→REDIRECT→IDLE.
  - MEPC: addr 0x341, we=1, data={pc[XLEN-1:2],2'b00}.
  - MCAUSE: addr 0x342, we=1, data=cause.
  - MSTATUS: addr 0x300, we=1, data=csr_rd with MPIE←MIE (bit7←bit3), MIE←0, MPP←2'b11.
  - MTVEC: addr 0x305, we=0. Latch the target:
    - mode (csr_rd[1:0]) ==01 and the cause is an interrupt: {base,2'b00}+4·code.
    - Any other case: {base,2'b00}, including modes 10 and 11.
- MRET path: IDLE→MEPC→MSTATUS→REDIRECT.
  - MEPC: we=0; latch csr_rd as the target.
  - MSTATUS: MIE←MPIE, MPIE←1, MPP←00.
- REDIRECT: trap_done=1, ic_clean=1, t_target=latched target.
- trap_status and irq are ignored outside IDLE.
- Idle bus values: csr_trap_we=0, csr_trap_address=0, csr_trap_write_data=0 in IDLE, REDIRECT and DEBUG.

## Timing
- Reset values: all outputs 0, state IDLE, latched target 0.
- Reset mid-sequence returns to IDLE immediately. CSR writes already committed remain; no rollback.
- trap_busy is combinational-high in IDLE in the cycle a trap is accepted. It stays high through REDIRECT and falls in the following IDLE cycle.
- Exception/interrupt accepted in cycle T: MEPC write at T+1, MCAUSE at T+2, MSTATUS at T+3, MTVEC read at T+4, trap_done at T+5.
- MRET accepted in T: trap_done at T+3.
- A new trap may be accepted in the cycle right after REDIRECT.
- Accepting an irq does not clear it; the source must drop irq before mstatus.MIE is re-enabled.

## Configuration
- TRAP_SEQ_DEBUG_EN defined:
  - EBREAK enters DEBUG from IDLE at T+1: debug_mode=1, trap_busy=1, no CSR writes.
  - On debug_resume in DEBUG: next cycle is REDIRECT with target pc+4, and debug_mode falls in that cycle.
- TRAP_SEQ_DEBUG_EN undefined:
  - EBREAK is an exception with cause 3.
  - debug_mode is tied 0, debug_resume is ignored, and the DEBUG state is not built.

## Test plan
- ECALL at pc=0x0000_1004, mtvec=0x0000_8000: writes 0x341←0x1004, 0x342←11, mstatus MIE 1→0 / MPIE←1; trap_done at T+5 with t_target=0x8000.
- irq=4'b0110, mstatus_mie=1, mtvec=0x0000_8001 (vectored): cause 0x8000_0011, t_target=0x8000+4·17=0x8044.
- Simultaneous illegal + irq[0]: cause 2 is taken; irq is ignored until IDLE; mstatus_mie=0 blocks irq entirely.
- MRET with mepc=0x0000_2000, MPIE=1: trap_done at T+3, t_target=0x2000, MIE=1.
- rst low during MCAUSE: all outputs 0 asynchronously; the mepc write has already landed; after reset a new ECALL runs the full sequence.
- With TRAP_SEQ_DEBUG_EN, EBREAK at pc=0x3000: debug_mode=1 until debug_resume; then trap_done with t_target=0x3004. Without the macro: cause 3, vectored to the mtvec base.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle machine-mode trap entry / MRET return sequencer.
// Serialises mepc/mcause/mstatus/mtvec through one CSR port and redirects the PC.
// Optional debug halt on EBREAK is built when TRAP_SEQ_DEBUG_EN is defined.
module trap_sequencer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NIRQ     = 4,
  parameter int unsigned IRQ_BASE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      trap_status,
  input  logic [NIRQ-1:0] irq,
  input  logic            mstatus_mie,
  input  logic            debug_resume,
  input  logic [XLEN-1:0] csr_rd,
  output logic [XLEN-1:0] t_target,
  output logic            trap_done,
  output logic            trap_busy,
  output logic            ic_clean,
  output logic            debug_mode,
  output logic [11:0]     csr_trap_address,
  output logic [XLEN-1:0] csr_trap_write_data,
  output logic            csr_trap_we
);

  localparam int unsigned IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  localparam int unsigned CW = XLEN - 1;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [2:0] TS_NONE   = 3'b000;
  localparam logic [2:0] TS_MRET   = 3'b110;
`ifdef TRAP_SEQ_DEBUG_EN
  localparam logic [2:0] TS_EBREAK = 3'b001;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS, S_MTVEC, S_REDIRECT
`ifdef TRAP_SEQ_DEBUG_EN
    , S_DEBUG
`endif
  } state_t;

  typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            irq_hit;
  logic [IW-1:0]   irq_idx;
  logic [3:0]      exc_code;

  // Lowest-numbered pending interrupt line
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (irq[i]) begin
        irq_hit = 1'b1;
        irq_idx = IW'(i);
      end
    end
  end

  // Synchronous exception cause codes; reserved encodings report illegal instruction
  always_comb begin
    case (trap_status)
      3'b001:  exc_code = 4'd3;
      3'b010:  exc_code = 4'd11;
      3'b011:  exc_code = 4'd0;
      3'b100:  exc_code = 4'd2;
      3'b101:  exc_code = 4'd4;
      default: exc_code = 4'd2;
    endcase
  end

  // State and latched trap context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      kind_q   <= K_EXC;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  assign t_target = target_q;

  // Next state, CSR port and redirect outputs
  always_comb begin
    state_d             = state_q;
    kind_d              = kind_q;
    pc_d                = pc_q;
    cause_d             = cause_q;
    target_d            = target_q;
    trap_busy           = 1'b0;
    trap_done           = 1'b0;
    ic_clean            = 1'b0;
    csr_trap_address    = '0;
    csr_trap_we         = 1'b0;
    csr_trap_write_data = '0;
`ifdef TRAP_SEQ_DEBUG_EN
    debug_mode          = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Acceptance stall is combinational, so keep it quiet while reset is held
        if (trap_status != TS_NONE) begin
          trap_busy = rst;
          pc_d      = pc;
          if (trap_status == TS_MRET) begin
            kind_d  = K_MRET;
            state_d = S_MEPC;
          end
`ifdef TRAP_SEQ_DEBUG_EN
          else if (trap_status == TS_EBREAK) begin
            state_d = S_DEBUG;
          end
`endif
          else begin
            kind_d  = K_EXC;
            cause_d = XLEN'(exc_code);
            state_d = S_MEPC;
          end
        end else if (mstatus_mie && irq_hit) begin
          trap_busy = rst;
          pc_d      = pc;
          kind_d    = K_IRQ;
          cause_d   = {1'b1, CW'(IRQ_BASE) + CW'(irq_idx)};
          state_d   = S_MEPC;
        end
      end
      S_MEPC: begin
        trap_busy        = 1'b1;
        csr_trap_address = ADDR_MEPC;
        if (kind_q == K_MRET) begin
          target_d = csr_rd;
          state_d  = S_MSTATUS;
        end else begin
          csr_trap_we         = 1'b1;
          csr_trap_write_data = pc_q & ~XLEN'(3);
          state_d             = S_MCAUSE;
        end
      end
      S_MCAUSE: begin
        trap_busy           = 1'b1;
        csr_trap_address    = ADDR_MCAUSE;
        csr_trap_we         = 1'b1;
        csr_trap_write_data = cause_q;
        state_d             = S_MSTATUS;
      end
      S_MSTATUS: begin
        trap_busy           = 1'b1;
        csr_trap_address    = ADDR_MSTATUS;
        csr_trap_we         = 1'b1;
        csr_trap_write_data = csr_rd;
        if (kind_q == K_MRET) begin
          csr_trap_write_data[3]     = csr_rd[7];
          csr_trap_write_data[7]     = 1'b1;
          csr_trap_write_data[12:11] = 2'b00;
          state_d                    = S_REDIRECT;
        end else begin
          csr_trap_write_data[7]     = csr_rd[3];
          csr_trap_write_data[3]     = 1'b0;
          csr_trap_write_data[12:11] = 2'b11;
          state_d                    = S_MTVEC;
        end
      end
      S_MTVEC: begin
        trap_busy        = 1'b1;
        csr_trap_address = ADDR_MTVEC;
        if (kind_q == K_IRQ && csr_rd[1:0] == 2'b01) begin
          target_d = {csr_rd[XLEN-1:2], 2'b00} + {cause_q[XLEN-3:0], 2'b00};
        end else begin
          target_d = {csr_rd[XLEN-1:2], 2'b00};
        end
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        trap_busy = 1'b1;
        trap_done = 1'b1;
        ic_clean  = 1'b1;
        state_d   = S_IDLE;
      end
`ifdef TRAP_SEQ_DEBUG_EN
      S_DEBUG: begin
        trap_busy  = 1'b1;
        debug_mode = 1'b1;
        if (debug_resume) begin
          target_d = pc_q + XLEN'(4);
          state_d  = S_REDIRECT;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifndef TRAP_SEQ_DEBUG_EN
  // Debug halt not built: mode tied low, resume request has no effect
  logic unused_debug_resume;
  assign unused_debug_resume = debug_resume;
  assign debug_mode          = 1'b0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer: CSR file model plus a cause/target/mstatus predictor.
module tb_trap_sequencer;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NIRQ     = 4;
  localparam int unsigned IRQ_BASE = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     pc = '0;
  logic [2:0]      trap_status = '0;
  logic [NIRQ-1:0] irq = '0;
  logic            mstatus_mie;
  logic            debug_resume = 1'b0;
  logic [31:0]     csr_rd;
  logic [31:0]     t_target;
  logic            trap_done, trap_busy, ic_clean, debug_mode, csr_trap_we;
  logic [11:0]     csr_trap_address;
  logic [31:0]     csr_trap_write_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.XLEN(XLEN), .NIRQ(NIRQ), .IRQ_BASE(IRQ_BASE)) dut (
    .clk(clk), .rst(rst), .pc(pc), .trap_status(trap_status), .irq(irq),
    .mstatus_mie(mstatus_mie), .debug_resume(debug_resume), .csr_rd(csr_rd),
    .t_target(t_target), .trap_done(trap_done), .trap_busy(trap_busy),
    .ic_clean(ic_clean), .debug_mode(debug_mode),
    .csr_trap_address(csr_trap_address), .csr_trap_write_data(csr_trap_write_data),
    .csr_trap_we(csr_trap_we)
  );

  // CSR file model
  logic [31:0] mepc_m = '0, mcause_m = '0, mstatus_m = '0, mtvec_m = '0;
  logic        pre_en = 1'b0;
  logic [31:0] pre_mepc = '0, pre_mcause = '0, pre_mstatus = '0, pre_mtvec = '0;

  always @(posedge clk) begin
    if (csr_trap_we) begin
      case (csr_trap_address)
        12'h341: mepc_m    <= csr_trap_write_data;
        12'h342: mcause_m  <= csr_trap_write_data;
        12'h300: mstatus_m <= csr_trap_write_data;
        12'h305: mtvec_m   <= csr_trap_write_data;
        default: ;
      endcase
    end else if (pre_en) begin
      mepc_m    <= pre_mepc;
      mcause_m  <= pre_mcause;
      mstatus_m <= pre_mstatus;
      mtvec_m   <= pre_mtvec;
    end
  end

  always_comb begin
    case (csr_trap_address)
      12'h341: csr_rd = mepc_m;
      12'h342: csr_rd = mcause_m;
      12'h300: csr_rd = mstatus_m;
      12'h305: csr_rd = mtvec_m;
      default: csr_rd = 32'h0;
    endcase
  end

  assign mstatus_mie = mstatus_m[3];

  int exc_tab [0:7] = '{0, 3, 11, 0, 2, 4, 0, 2};

  function automatic int lowest(input logic [NIRQ-1:0] v);
    for (int i = 0; i < int'(NIRQ); i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic preload(input logic [31:0] mp, input logic [31:0] mc,
                         input logic [31:0] ms, input logic [31:0] mt);
    @(posedge clk); #1;
    pre_mepc = mp; pre_mcause = mc; pre_mstatus = ms; pre_mtvec = mt; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // One trap or return, predicted from the current CSR model state
  task automatic do_trap(input logic [2:0] ts, input logic [NIRQ-1:0] irqv,
                         input logic [31:0] pcv, input string tag);
    bit mret, is_irq, taken, bad_busy, done_ic;
    int code, lat, done_at;
    logic [31:0] ecause, etgt, emst, emepc, base, tgt_seen;
    mret   = (ts == 3'b110);
    is_irq = (ts == 3'b000) && mstatus_m[3] && (irqv != '0);
    taken  = (ts != 3'b000) || is_irq;
    base   = mtvec_m & ~32'h3;
    code   = 0;
    ecause = mcause_m; emepc = mepc_m; emst = mstatus_m; etgt = 32'h0; lat = 0;
    if (mret) begin
      etgt = mepc_m;
      emst[3] = mstatus_m[7]; emst[7] = 1'b1; emst[12:11] = 2'b00;
      lat = 3;
    end else if (taken) begin
      if (is_irq) begin
        code   = int'(IRQ_BASE) + lowest(irqv);
        ecause = 32'h8000_0000 | 32'(code);
      end else begin
        ecause = 32'(exc_tab[ts]);
      end
      etgt  = (is_irq && mtvec_m[1:0] == 2'b01) ? base + 32'(4 * code) : base;
      emepc = pcv & ~32'h3;
      emst[7] = mstatus_m[3]; emst[3] = 1'b0; emst[12:11] = 2'b11;
      lat = 5;
    end

    @(posedge clk); #1;
    pc = pcv; trap_status = ts; irq = irqv; #1;
    n_vec++;
    if (trap_busy !== taken) begin
      n_err++; $display("FAIL %s accept_busy got=%b exp=%b", tag, trap_busy, taken);
    end

    done_at = 0; bad_busy = 1'b0; tgt_seen = 32'h0; done_ic = 1'b0;
    if (taken) begin
      for (int n = 1; n <= 12 && done_at == 0; n++) begin
        @(posedge clk); #1;
        trap_status = (n < lat) ? 3'($urandom_range(0, 7)) : 3'b000;
        pc = $urandom;
        if (n >= lat) irq = '0;
        #1;
        if (n == 1) begin
          n_vec++;
          if (csr_trap_address !== 12'h341 || csr_trap_we !== !mret) begin
            n_err++;
            $display("FAIL %s mepc_step got addr=%h we=%b exp addr=341 we=%b",
                     tag, csr_trap_address, csr_trap_we, !mret);
          end
        end
        if (trap_done === 1'b1) begin
          done_at = n; tgt_seen = t_target; done_ic = ic_clean;
        end else if (trap_busy !== 1'b1) begin
          bad_busy = 1'b1;
        end
      end
      n_vec++;
      if (done_at != lat) begin
        n_err++; $display("FAIL %s done_latency got=%0d exp=%0d", tag, done_at, lat);
      end
      n_vec++;
      if (bad_busy || done_ic !== 1'b1) begin
        n_err++; $display("FAIL %s busy_or_flush got busy_drop=%b ic=%b exp 0/1", tag, bad_busy, done_ic);
      end
      n_vec++;
      if (tgt_seen !== etgt) begin
        n_err++; $display("FAIL %s target got=%h exp=%h", tag, tgt_seen, etgt);
      end
    end

    @(posedge clk); #1;
    trap_status = 3'b000; irq = '0; #1;
    n_vec++;
    if (trap_busy !== 1'b0 || trap_done !== 1'b0) begin
      n_err++; $display("FAIL %s idle_after got busy=%b done=%b exp 0/0", tag, trap_busy, trap_done);
    end
    n_vec++;
    if (mepc_m !== emepc || mcause_m !== ecause || mstatus_m !== emst) begin
      n_err++;
      $display("FAIL %s csr_state got mepc=%h mcause=%h mstatus=%h exp mepc=%h mcause=%h mstatus=%h",
               tag, mepc_m, mcause_m, mstatus_m, emepc, ecause, emst);
    end
  endtask

  task automatic test_reset();
    logic [80:0] outs;
    trap_status = 3'b010; irq = '1; pc = 32'h1234;
    #12;
    outs = {trap_busy, trap_done, ic_clean, debug_mode, csr_trap_we,
            csr_trap_address, csr_trap_write_data, t_target};
    n_vec++;
    if (outs !== '0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    trap_status = 3'b000; irq = '0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_ecall();
    preload(32'h0, 32'h0, 32'h0000_0008, 32'h0000_8000);
    do_trap(3'b010, '0, 32'h0000_1004, "ecall");
  endtask

  task automatic test_irq_vectored();
    preload(32'h0, 32'h0, 32'h0000_0008, 32'h0000_8001);
    do_trap(3'b000, 4'b0110, 32'h0000_0a0c, "irq_vectored");
  endtask

  task automatic test_priority();
    preload(32'h0, 32'h0, 32'h0000_0008, 32'h0000_8001);
    do_trap(3'b100, 4'b0001, 32'h0000_0500, "illegal_over_irq");
    preload(32'h0, 32'h0, 32'h0000_0000, 32'h0000_8000);
    do_trap(3'b000, 4'b1111, 32'h0000_0600, "irq_masked");
    preload(32'h0, 32'h0, 32'h0000_0008, 32'h0000_8000);
    do_trap(3'b111, 4'b0000, 32'h0000_0702, "reserved");
  endtask

  task automatic test_mret();
    preload(32'h0000_2000, 32'h0000_000b, 32'h0000_1880, 32'h0000_8000);
    do_trap(3'b110, '0, 32'h0000_8010, "mret");
  endtask

  task automatic test_reset_mid();
    logic [80:0] outs;
    preload(32'h0, 32'h0000_001f, 32'h0000_0008, 32'h0000_8000);
    @(posedge clk); #1; pc = 32'h0000_4008; trap_status = 3'b010;
    @(posedge clk); #1; trap_status = 3'b000;
    @(posedge clk); #1;
    n_vec++;
    if (csr_trap_address !== 12'h342 || csr_trap_we !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_mcause_step got addr=%h we=%b exp 342/1", csr_trap_address, csr_trap_we);
    end
    #1 rst = 1'b0;
    #1;
    outs = {trap_busy, trap_done, ic_clean, debug_mode, csr_trap_we,
            csr_trap_address, csr_trap_write_data, t_target};
    n_vec++;
    if (outs !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs got=%h exp=0", outs);
    end
    n_vec++;
    if (mepc_m !== 32'h0000_4008) begin
      n_err++; $display("FAIL reset_mid_mepc got=%h exp=00004008", mepc_m);
    end
    @(posedge clk); #1;
    n_vec++;
    if (mcause_m !== 32'h0000_001f) begin
      n_err++; $display("FAIL reset_mid_mcause got=%h exp=0000001f", mcause_m);
    end
    @(negedge clk); rst = 1'b1;
    do_trap(3'b010, '0, 32'h0000_5000, "ecall_after_reset");
  endtask

  task automatic test_ebreak();
    preload(32'h0000_0111, 32'h0, 32'h0000_0008, 32'h0000_8001);
`ifdef TRAP_SEQ_DEBUG_EN
    begin
      bit bad;
      @(posedge clk); #1; pc = 32'h0000_3000; trap_status = 3'b001; #1;
      n_vec++;
      if (trap_busy !== 1'b1) begin
        n_err++; $display("FAIL ebreak_accept got busy=%b exp 1", trap_busy);
      end
      bad = 1'b0;
      for (int n = 0; n < 4; n++) begin
        @(posedge clk); #1; trap_status = 3'($urandom_range(0, 7)); pc = $urandom; #1;
        if (debug_mode !== 1'b1 || trap_busy !== 1'b1 || csr_trap_we !== 1'b0 || trap_done !== 1'b0) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
        n_err++; $display("FAIL ebreak_halt got debug=%b busy=%b we=%b exp 1/1/0", debug_mode, trap_busy, csr_trap_we);
      end
      @(posedge clk); #1; trap_status = 3'b000; debug_resume = 1'b1;
      @(posedge clk); #1; debug_resume = 1'b0; #1;
      n_vec++;
      if (trap_done !== 1'b1 || t_target !== 32'h0000_3004 || debug_mode !== 1'b0) begin
        n_err++; $display("FAIL ebreak_resume got done=%b target=%h debug=%b exp 1/00003004/0",
                          trap_done, t_target, debug_mode);
      end
      @(posedge clk); #1;
      n_vec++;
      if (trap_busy !== 1'b0 || mepc_m !== 32'h0000_0111 || mstatus_m !== 32'h0000_0008) begin
        n_err++; $display("FAIL ebreak_no_csr got busy=%b mepc=%h mstatus=%h exp 0/00000111/00000008",
                          trap_busy, mepc_m, mstatus_m);
      end
    end
`else
    do_trap(3'b001, '0, 32'h0000_3000, "ebreak");
`endif
  endtask

  task automatic test_back_to_back();
    preload(32'h0, 32'h0, 32'h0000_0008, 32'h0000_9000);
    @(posedge clk); #1; pc = 32'h0000_0100; trap_status = 3'b010;
    for (int n = 1; n <= 5; n++) begin @(posedge clk); #1; trap_status = 3'b000; end
    #1;
    n_vec++;
    if (trap_done !== 1'b1 || t_target !== 32'h0000_9000) begin
      n_err++; $display("FAIL b2b_first got done=%b target=%h exp 1/00009000", trap_done, t_target);
    end
    @(posedge clk); #1; pc = 32'h0000_0200; trap_status = 3'b100; #1;
    n_vec++;
    if (trap_busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept got busy=%b exp 1", trap_busy);
    end
    for (int n = 1; n <= 5; n++) begin @(posedge clk); #1; trap_status = 3'b000; end
    #1;
    n_vec++;
    if (trap_done !== 1'b1 || mcause_m !== 32'd2 || mepc_m !== 32'h0000_0200) begin
      n_err++; $display("FAIL b2b_second got done=%b mcause=%h mepc=%h exp 1/00000002/00000200",
                        trap_done, mcause_m, mepc_m);
    end
  endtask

  task automatic test_random();
    logic [2:0] ts;
    for (int k = 0; k < 40; k++) begin
      preload($urandom, $urandom, $urandom & 32'h0000_1888, $urandom);
      ts = 3'($urandom_range(0, 7));
`ifdef TRAP_SEQ_DEBUG_EN
      if (ts == 3'b001) ts = 3'b010;
`endif
      do_trap(ts, NIRQ'($urandom), $urandom, $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_irq_vectored();
    test_priority();
    test_mret();
    test_reset_mid();
    test_ebreak();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
